// File: rtl/logic_2048_nxn_pkg.sv
// Shared constants for the NxN 2048 move engine: move directions,
// FSM state encodings and the spawn LFSR.
package logic_2048_nxn_pkg;

   localparam logic [1:0] DIR_L = 2'd0;
   localparam logic [1:0] DIR_R = 2'd1;
   localparam logic [1:0] DIR_U = 2'd2;
   localparam logic [1:0] DIR_D = 2'd3;

   localparam logic [2:0] ST_INIT  = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_MERGE = 3'd2;
   localparam logic [2:0] ST_SPAWN = 3'd3;
   localparam logic [2:0] ST_CHECK = 3'd4;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One step of the 16-bit Galois LFSR (shift right, xor taps when bit 0 falls out).
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/logic_2048_nxn_line_merge.sv
// Combinational slide-and-merge of one N-tile line toward index 0.
// Tiles are exponents (0 = empty). Each tile merges at most once per move and
// tiles already at the maximum exponent never merge.
module line_merge #(
   parameter int N       = 4,
   parameter int W       = 4,
   parameter int SCORE_W = 20
) (
   input  logic [N*W-1:0]     line_in,
   output logic [N*W-1:0]     line_out,
   output logic [SCORE_W-1:0] gain,
   output logic               changed
);

   localparam logic [W-1:0] MAX_EXP = {W{1'b1}};

   logic [W-1:0] slid       [N];
   logic [W-1:0] merged     [N];
   logic [W-1:0] compacted  [N];

   // Slide non-zero tiles toward index 0; each pass carries the first gap to the end
   always_comb begin
      for (int i = 0; i < N; i++) slid[i] = line_in[i*W +: W];
      for (int p = 0; p < N-1; p++) begin
         for (int i = 0; i < N-1; i++) begin
            if (slid[i] == '0) begin
               slid[i]   = slid[i+1];
               slid[i+1] = '0;
            end
         end
      end
   end

   // Merge equal neighbours scanning from index 0; a merged pair skips its partner
   always_comb begin
      logic skip;
      skip = 1'b0;
      gain = '0;
      for (int i = 0; i < N; i++) merged[i] = slid[i];
      for (int i = 0; i < N-1; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (slid[i] != '0 && slid[i] == slid[i+1] && slid[i] != MAX_EXP) begin
            merged[i]   = slid[i] + W'(1);
            merged[i+1] = '0;
            gain        = gain + (SCORE_W'(1) << (slid[i] + W'(1)));
            skip        = 1'b1;
         end
      end
   end

   // Close the holes left by merges and repack the line
   always_comb begin
      for (int i = 0; i < N; i++) compacted[i] = merged[i];
      for (int p = 0; p < N-1; p++) begin
         for (int i = 0; i < N-1; i++) begin
            if (compacted[i] == '0) begin
               compacted[i]   = compacted[i+1];
               compacted[i+1] = '0;
            end
         end
      end
      for (int i = 0; i < N; i++) line_out[i*W +: W] = compacted[i];
      changed = (line_out != line_in);
   end

endmodule

// File: rtl/logic_2048_nxn.sv
// NxN 2048 move engine. One line is slid/merged per MERGE cycle through a
// single shared line_merge; a tile is spawned only when the move changed the
// board, then win / game-over are evaluated in CHECK. busy is low only in IDLE.
module logic_2048_nxn
   import logic_2048_nxn_pkg::*;
#(
   parameter int          N       = 4,
   parameter int          W       = 4,
   parameter int          SCORE_W = 20,
   parameter int          WIN_EXP = 11,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btnL,
   input  logic                 btnR,
   input  logic                 btnU,
   input  logic                 btnD,
   output logic [N*N*W-1:0]     board_out,
   output logic [SCORE_W-1:0]   score,
   output logic                 busy,
   output logic                 won,
   output logic                 game_over
);

   localparam int CELLS = N * N;
   localparam int KW    = $clog2(N);
   localparam int PW    = $clog2(CELLS);

   logic [2:0]         state_q, state_d;
   logic [CELLS*W-1:0] board_q, board_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               won_q, won_d;
   logic               game_over_q, game_over_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [3:0]         last_btn_q, last_btn_d;
   logic [1:0]         dir_q, dir_d;
   logic [KW-1:0]      k_q, k_d;
   logic               changed_q, changed_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      scan_q, scan_d;
   logic               spawn_more_q, spawn_more_d;

   logic [3:0]         btn_now, btn_edge;
   logic [N*W-1:0]     line_in, line_out;
   logic [SCORE_W-1:0] line_gain;
   logic               line_changed;
   logic [PW-1:0]      ptr_seed;
   logic               ptr_empty;
   logic               any_win, any_empty, any_pair;
   logic [SCORE_W:0]   score_sum;

   // Board cell visited at position j of line k for a given direction.
   function automatic int cell_of(input logic [1:0] d, input int k, input int j);
      case (d)
         DIR_L:   return k * N + j;
         DIR_R:   return k * N + (N - 1 - j);
         DIR_U:   return j * N + k;
         default: return (N - 1 - j) * N + k;
      endcase
   endfunction

   // Button edges (bit 3 = L .. bit 0 = D) and spawn start pointer from the LFSR
   always_comb begin
      btn_now  = {btnL, btnR, btnU, btnD};
      btn_edge = btn_now & ~last_btn_q;
      ptr_seed = (int'(lfsr_q[5:0]) >= CELLS) ? '0 : PW'(lfsr_q[5:0]);
      ptr_empty = 1'b0;
      for (int c = 0; c < CELLS; c++)
         if (int'(ptr_q) == c) ptr_empty = (board_q[c*W +: W] == '0);
   end

   // Gather the active line from the board in the direction's scan order
   always_comb begin
      line_in = '0;
      for (int j = 0; j < N; j++)
         for (int c = 0; c < CELLS; c++)
            if (cell_of(dir_q, int'(k_q), j) == c) line_in[j*W +: W] = board_q[c*W +: W];
   end

   line_merge #(.N(N), .W(W), .SCORE_W(SCORE_W)) u_line_merge (
      .line_in  (line_in),
      .line_out (line_out),
      .gain     (line_gain),
      .changed  (line_changed)
   );

   // Whole-board scan for a winning tile, empty cells and mergeable neighbours
   always_comb begin
      any_win   = 1'b0;
      any_empty = 1'b0;
      any_pair  = 1'b0;
      for (int c = 0; c < CELLS; c++) begin
         if (board_q[c*W +: W] == '0) any_empty = 1'b1;
         if (int'(board_q[c*W +: W]) >= WIN_EXP) any_win = 1'b1;
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N-1; c++)
            if (board_q[(r*N+c)*W +: W] == board_q[(r*N+c+1)*W +: W]) any_pair = 1'b1;
      for (int r = 0; r < N-1; r++)
         for (int c = 0; c < N; c++)
            if (board_q[(r*N+c)*W +: W] == board_q[((r+1)*N+c)*W +: W]) any_pair = 1'b1;
   end

   // Next-state logic: edge arbitration, per-line merge, spawn scan, end-of-move checks
   always_comb begin
      state_d      = state_q;
      board_d      = board_q;
      score_d      = score_q;
      won_d        = won_q;
      game_over_d  = game_over_q;
      lfsr_d       = lfsr_step(lfsr_q);
      last_btn_d   = btn_now;
      dir_d        = dir_q;
      k_d          = k_q;
      changed_d    = changed_q;
      ptr_d        = ptr_q;
      scan_d       = scan_q;
      spawn_more_d = spawn_more_q;
      score_sum    = {1'b0, score_q} + {1'b0, line_gain};
      case (state_q)
         ST_INIT: begin
            // two spawn passes back to back, then CHECK
            state_d      = ST_SPAWN;
            ptr_d        = ptr_seed;
            scan_d       = '0;
            spawn_more_d = 1'b1;
         end
         ST_IDLE: begin
            // edges outside IDLE or after game over are dropped, never queued
            if (!game_over_q && btn_edge != 4'b0000) begin
               if (btn_edge[3])      dir_d = DIR_L;
               else if (btn_edge[2]) dir_d = DIR_R;
               else if (btn_edge[1]) dir_d = DIR_U;
               else                  dir_d = DIR_D;
               k_d       = '0;
               changed_d = 1'b0;
               state_d   = ST_MERGE;
            end
         end
         ST_MERGE: begin
            for (int j = 0; j < N; j++)
               for (int c = 0; c < CELLS; c++)
                  if (cell_of(dir_q, int'(k_q), j) == c) board_d[c*W +: W] = line_out[j*W +: W];
            changed_d = changed_q | line_changed;
            score_d   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
            if (int'(k_q) == N-1) begin
               state_d      = changed_d ? ST_SPAWN : ST_IDLE;
               ptr_d        = ptr_seed;
               scan_d       = '0;
               spawn_more_d = 1'b0;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         ST_SPAWN: begin
            if (ptr_empty)
               for (int c = 0; c < CELLS; c++)
                  if (int'(ptr_q) == c) board_d[c*W +: W] = (lfsr_q[3:0] == 4'd0) ? W'(2) : W'(1);
            if (ptr_empty || int'(scan_q) == CELLS-1) begin
               if (spawn_more_q) begin
                  spawn_more_d = 1'b0;
                  ptr_d        = ptr_seed;
                  scan_d       = '0;
               end else begin
                  state_d = ST_CHECK;
               end
            end else begin
               ptr_d  = (int'(ptr_q) == CELLS-1) ? '0 : ptr_q + PW'(1);
               scan_d = scan_q + PW'(1);
            end
         end
         ST_CHECK: begin
            won_d       = won_q | any_win;
            game_over_d = game_over_q | (!any_empty && !any_pair);
            state_d     = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State registers; reset aborts any move in flight with no partial write
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         board_q      <= '0;
         score_q      <= '0;
         won_q        <= 1'b0;
         game_over_q  <= 1'b0;
         lfsr_q       <= SEED;
         last_btn_q   <= 4'b0000;
         dir_q        <= DIR_L;
         k_q          <= '0;
         changed_q    <= 1'b0;
         ptr_q        <= '0;
         scan_q       <= '0;
         spawn_more_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         board_q      <= board_d;
         score_q      <= score_d;
         won_q        <= won_d;
         game_over_q  <= game_over_d;
         lfsr_q       <= lfsr_d;
         last_btn_q   <= last_btn_d;
         dir_q        <= dir_d;
         k_q          <= k_d;
         changed_q    <= changed_d;
         ptr_q        <= ptr_d;
         scan_q       <= scan_d;
         spawn_more_q <= spawn_more_d;
      end
   end

   assign board_out = board_q;
   assign score     = score_q;
   assign busy      = (state_q != ST_IDLE);
   assign won       = won_q;
   assign game_over = game_over_q;

endmodule
